// File: rtl/ysyx_220053_dec_pkg.sv
// Decode stage shared definitions: RV opcode map, instruction format enum,
// stage FSM states and the decoded-instruction record carried by the stage.
// Pure declarations; no logic, no latency, no flow control.
package ysyx_220053_dec_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // ebreak is the single SYSTEM encoding with funct12 = 1 and all else zero
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] func3;
        logic [6:0] func7;
        fmt_e       fmt;
        logic       wen;
        logic       illegal;
        logic       ebreak;
    } dec_t;

endpackage

// File: rtl/ysyx_220053_dec_core.sv
// Combinational RV32/RV64 instruction decoder: fields, format, sign-extended imm.
// Latency 0 (pure combinational); no flow control of its own.
// No backpressure; the enclosing stage registers the result.
// Ports: instr (32b instruction) -> dec (decoded record), imm (XLEN immediate).
// Build option: YSYX_220053_TRAP_EN enables ebreak recognition (dec.ebreak).
module ysyx_220053_dec_core
    import ysyx_220053_dec_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    logic        is_system;
    logic        rv64_only;
    logic        listed;
    logic [31:0] imm32;

    always_comb begin
        dec       = '0;
        is_system = 1'b0;
        rv64_only = 1'b0;
        listed    = 1'b1;
        dec.op    = instr[6:0];
        dec.rd    = instr[11:7];
        dec.func3 = instr[14:12];
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];
        dec.func7 = instr[31:25];
        dec.fmt   = FMT_R;
        case (instr[6:0])
            OPC_OP:        dec.fmt = FMT_R;
            OPC_OP_32:     begin dec.fmt = FMT_R; rv64_only = 1'b1; end
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR:      dec.fmt = FMT_I;
            OPC_OP_IMM_32: begin dec.fmt = FMT_I; rv64_only = 1'b1; end
            OPC_SYSTEM:    begin dec.fmt = FMT_I; is_system = 1'b1; end
            OPC_STORE:     dec.fmt = FMT_S;
            OPC_BRANCH:    dec.fmt = FMT_B;
            OPC_LUI,
            OPC_AUIPC:     dec.fmt = FMT_U;
            OPC_JAL:       dec.fmt = FMT_J;
            default:       listed = 1'b0;
        endcase
        dec.illegal = (instr[1:0] != 2'b11) || !listed || (rv64_only && (XLEN == 32));
        // SYSTEM ops never write back; rd = x0 is architecturally a discard
        dec.wen = !dec.illegal && !is_system && (instr[11:7] != 5'd0) &&
                  (dec.fmt != FMT_S) && (dec.fmt != FMT_B);
`ifdef YSYX_220053_TRAP_EN
        dec.ebreak = (instr == EBREAK_INSTR);
`else
        dec.ebreak = 1'b0;
`endif
    end

    // Immediates are assembled at 32 bits, then widened by sign extension.
    always_comb begin
        case (dec.fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    if (XLEN > 32) begin : g_sext
        assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_nosext
        assign imm = imm32;
    end

endmodule

// File: rtl/ysyx_220053_dec_stage.sv
// Decode pipeline stage: decodes instr_i and registers the result with valid/ready.
// Latency 1 cycle from accept to out_valid_o; SKID=1 adds a one-entry skid buffer.
// Backpressure: SKID=1 in_ready_o is registered (skid empty); SKID=0 it is !out_valid_o || out_ready_i.
// Ports: clk/rst_n, flush_i, upstream in_valid_i/in_ready_o/instr_i/pc_i,
//        downstream out_valid_o/out_ready_i + decoded out_* fields, trap_o.
// Build option: YSYX_220053_TRAP_EN -> ebreak pulses trap_o and halts the stage
// until reset; without it ebreak is never flagged, so trap_o stays 0 and HALT is unreachable.
module ysyx_220053_dec_stage
    import ysyx_220053_dec_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [6:0]      out_op_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [2:0]      out_func3_o,
    output logic [6:0]      out_func7_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [2:0]      out_fmt_o,
    output logic            out_wen_o,
    output logic            out_illegal_o,
    output logic            trap_o
);

    typedef struct packed {
        dec_t            dec;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } entry_t;

    dec_t            in_dec;
    logic [XLEN-1:0] in_imm;
    entry_t          in_ent;
    entry_t          out_q, skid_q;
    logic            out_vld_q, skid_vld_q;
    logic            trap_q;
    state_e          state_q, state_d;
    logic            room, accept, out_fire, out_free;

    ysyx_220053_dec_core #(.XLEN(XLEN)) u_core (
        .instr (instr_i),
        .dec   (in_dec),
        .imm   (in_imm)
    );

    assign in_ent   = '{dec: in_dec, pc: pc_i, imm: in_imm};
    assign room     = (SKID != 0) ? !skid_vld_q : (!out_vld_q || out_ready_i);
    assign accept   = in_valid_i && in_ready_o;
    assign out_fire = out_vld_q && out_ready_i;
    assign out_free = !out_vld_q || out_ready_i;

    // Output register refills from the skid entry first so ordering is kept;
    // flush drops both entries and whatever is accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else if (flush_i) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (out_free) begin
            skid_vld_q <= 1'b0;
            if (skid_vld_q) begin
                out_vld_q <= 1'b1;
                out_q     <= skid_q;
            end else if (accept) begin
                out_vld_q <= 1'b1;
                out_q     <= in_ent;
            end else begin
                out_vld_q <= 1'b0;
            end
        end else if (accept && (SKID != 0)) begin
            skid_vld_q <= 1'b1;
            skid_q     <= in_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= out_fire && out_q.dec.ebreak;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; HALT is left only through reset (flush has no effect)
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_RUN) && out_fire && out_q.dec.ebreak) begin
            state_d = ST_HALT;
        end
    end

    // FSM: outputs
    always_comb begin
        in_ready_o = room && (state_q == ST_RUN);
    end

    assign trap_o        = trap_q;
    assign out_valid_o   = out_vld_q;
    assign out_pc_o      = out_q.pc;
    assign out_op_o      = out_q.dec.op;
    assign out_rd_o      = out_q.dec.rd;
    assign out_rs1_o     = out_q.dec.rs1;
    assign out_rs2_o     = out_q.dec.rs2;
    assign out_func3_o   = out_q.dec.func3;
    assign out_func7_o   = out_q.dec.func7;
    assign out_imm_o     = out_q.imm;
    assign out_fmt_o     = out_q.dec.fmt;
    assign out_wen_o     = out_q.dec.wen;
    assign out_illegal_o = out_q.dec.illegal;

endmodule
